// File: rtl/response_signature_analyzer_pkg.sv
// Shared types and defaults for the BIST response compactor.
// Holds the FSM state type, MISR defaults and response word layout.
package bist_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        COMPACT = 2'd2,
        DONE    = 2'd3
    } state_e;

    localparam int          DATA_W_DEF = 7;
    localparam int          SIG_W_DEF  = 32;
    localparam int          CNT_W_DEF  = 16;
    localparam logic [31:0] POLY_DEF   = 32'h04C11DB7;
    localparam logic [31:0] SEED_DEF   = 32'hFFFFFFFF;

    // Response word layout: {count[5:0], result}
    localparam int RESP_COUNT_MSB  = 6;
    localparam int RESP_RESULT_BIT = 0;

endpackage

// File: rtl/response_signature_analyzer_if.sv
// Control/response bundle between the BIST sequencer and the analyzer.
// master drives run control and responses, slave reports status.
interface response_signature_analyzer_if #(
    parameter int DATA_W = 7,
    parameter int SIG_W  = 32,
    parameter int CNT_W  = 16
);
    logic              start;
    logic [CNT_W-1:0]  num_samples;
    logic [3:0]        settle;
    logic [SIG_W-1:0]  golden;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_in;
    logic              busy;
    logic              done;
    logic              pass;
    logic [SIG_W-1:0]  signature;
    logic [CNT_W-1:0]  sample_count;

    modport master (
        output start, num_samples, settle, golden,
        output resp_valid, resp_in,
        input  busy, done, pass, signature, sample_count
    );

    modport slave (
        input  start, num_samples, settle, golden,
        input  resp_valid, resp_in,
        output busy, done, pass, signature, sample_count
    );
endinterface

// File: rtl/response_signature_analyzer_misr.sv
// Multiple-input signature register, reusable at any BIST endpoint.
// Shifts left, folds POLY in when the MSB leaves, xors in the data word.
module misr_core #(
    parameter int               SIG_W = 32,
    parameter logic [SIG_W-1:0] POLY  = 32'h04C11DB7,
    parameter logic [SIG_W-1:0] SEED  = 32'hFFFFFFFF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             en,
    input  logic [SIG_W-1:0] seed,
    input  logic [SIG_W-1:0] din,
    output logic [SIG_W-1:0] sig
);
    logic [SIG_W-1:0] sig_q;
    logic [SIG_W-1:0] sig_d;

    // Next signature: load wins over compaction
    always_comb begin
        sig_d = sig_q;
        if (load) begin
            sig_d = seed;
        end else if (en) begin
            sig_d = {sig_q[SIG_W-2:0], 1'b0}
                  ^ (sig_q[SIG_W-1] ? POLY : '0)
                  ^ din;
        end
    end

    // Signature register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) sig_q <= SEED;
        else        sig_q <= sig_d;
    end

    assign sig = sig_q;
endmodule

// File: rtl/response_signature_analyzer.sv
// BIST response compactor: skips settle cycles, folds responses into
// a MISR and compares the final signature with the latched golden value.
module response_signature_analyzer
    import bist_pkg::*;
#(
    parameter int               DATA_W = DATA_W_DEF,
    parameter int               SIG_W  = SIG_W_DEF,
    parameter logic [SIG_W-1:0] POLY   = POLY_DEF,
    parameter logic [SIG_W-1:0] SEED   = SEED_DEF,
    parameter int               CNT_W  = CNT_W_DEF
) (
    input logic                    clock,
    input logic                    reset,
    response_signature_analyzer_if.slave bus
);
    state_e           state_q, state_d;
    logic [3:0]       settle_q, settle_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SIG_W-1:0] golden_q, golden_d;
    logic [SIG_W-1:0] sig;
    logic [SIG_W-1:0] din;
    logic             load;
    logic             en;

    assign din = SIG_W'(bus.resp_in);

    // Run sequencing: start, settle countdown, sample absorption
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        num_d    = num_q;
        cnt_d    = cnt_q;
        golden_d = golden_q;
        load     = 1'b0;
        en       = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d  = SETTLE;
                    settle_d = bus.settle;
                    num_d    = bus.num_samples;
                    golden_d = bus.golden;
                    cnt_d    = '0;
                    load     = 1'b1;
                end
            end
            SETTLE: begin
                if (settle_q == 4'd0) begin
                    state_d = (num_q == '0) ? DONE : COMPACT;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end
            COMPACT: begin
                if (bus.resp_valid) begin
                    en    = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == num_q) state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and run-parameter registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            settle_q <= '0;
            num_q    <= '0;
            cnt_q    <= '0;
            golden_q <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            num_q    <= num_d;
            cnt_q    <= cnt_d;
            golden_q <= golden_d;
        end
    end

    misr_core #(
        .SIG_W (SIG_W),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_misr (
        .clock (clock),
        .reset (reset),
        .load  (load),
        .en    (en),
        .seed  (SEED),
        .din   (din),
        .sig   (sig)
    );

    // Status decodes come straight from registers only
    assign bus.busy         = (state_q == SETTLE) || (state_q == COMPACT);
    assign bus.done         = (state_q == DONE);
    assign bus.pass         = (state_q == DONE) && (sig == golden_q);
    assign bus.signature    = sig;
    assign bus.sample_count = cnt_q;
endmodule

// File: tb/tb_response_signature_analyzer.sv
// Randomized bench for response_signature_analyzer against a run-level
// model, plus directed literal checks for the seed and polynomial.
module tb_response_signature_analyzer;
    localparam logic [31:0] POLY = 32'h04C11DB7;
    localparam logic [31:0] SEED = 32'hFFFFFFFF;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    response_signature_analyzer_if #(.DATA_W(7), .SIG_W(32), .CNT_W(16)) vif ();
    response_signature_analyzer_if #(.DATA_W(7), .SIG_W(32), .CNT_W(16)) vif2 ();

    response_signature_analyzer #(
        .DATA_W(7), .SIG_W(32), .POLY(POLY), .SEED(SEED), .CNT_W(16)
    ) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (vif.slave)
    );

    response_signature_analyzer #(
        .DATA_W(7), .SIG_W(32), .POLY(POLY), .SEED(32'h0), .CNT_W(16)
    ) dut0 (
        .clock (clk),
        .reset (rst_n),
        .bus   (vif2.slave)
    );

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    logic        m_busy, m_done, m_pass;
    logic [31:0] m_sig;
    logic [15:0] m_cnt;
    logic [6:0]  dq[$];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Signature rule: polynomial division step with the data word added
    function automatic logic [31:0] fold(input logic [31:0] s,
                                         input logic [6:0] d);
        logic [32:0] w;
        w = {s, 1'b0};
        if (w[32]) w[31:0] = w[31:0] ^ POLY;
        return w[31:0] ^ {25'd0, d};
    endfunction

    task automatic model_reset();
        m_busy = 1'b0; m_done = 1'b0; m_pass = 1'b0;
        m_sig = SEED; m_cnt = '0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", {31'd0, vif.busy}, {31'd0, m_busy});
            check("done", {31'd0, vif.done}, {31'd0, m_done});
            check("signature", vif.signature, m_sig);
            check("sample_count", {16'd0, vif.sample_count}, {16'd0, m_cnt});
            if (m_done) check("pass", {31'd0, vif.pass}, {31'd0, m_pass});
        end
    end

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) begin
            vif.start = 1'b0;
            vif.resp_valid = 1'($urandom);
            vif.resp_in = 7'($urandom);
            @(posedge clk); #1;
        end
        vif.resp_valid = 1'b0;
    endtask

    task automatic junk();
        vif.start = ($urandom_range(3) == 0);
        vif.golden = $urandom;
        vif.num_samples = 16'($urandom_range(40));
        vif.settle = 4'($urandom);
        vif.resp_valid = 1'($urandom);
        vif.resp_in = 7'($urandom);
    endtask

    task automatic run(input int n, input int st, input bit bad_gold,
                       input int pct, input logic [31:0] vpat,
                       input bit use_pat, input int abort_at);
        logic [31:0] good, gold;
        int got, vi, guard;
        bit v;
        while (dq.size() < n) dq.push_back(7'($urandom));
        good = SEED;
        for (int i = 0; i < n; i++) good = fold(good, dq[i]);
        gold = bad_gold ? (good ^ 32'h1) : good;
        vif.start = 1'b1;
        vif.num_samples = 16'(n);
        vif.settle = 4'(st);
        vif.golden = gold;
        vif.resp_valid = 1'($urandom);
        vif.resp_in = 7'($urandom);
        @(posedge clk); #1;
        m_busy = 1'b1; m_done = 1'b0; m_pass = 1'b0;
        m_sig = SEED; m_cnt = '0;
        for (int k = 0; k <= st; k++) begin
            junk();
            @(posedge clk); #1;
            if (k == st && n == 0) begin
                m_busy = 1'b0; m_done = 1'b1; m_pass = (m_sig == gold);
            end
        end
        got = 0; vi = 0; guard = 0;
        while (got < n && guard < 2000) begin
            junk();
            v = use_pat ? vpat[vi] : ($urandom_range(99) < pct);
            vi++; guard++;
            vif.resp_valid = v;
            if (v) vif.resp_in = dq[got];
            @(posedge clk); #1;
            if (v) begin
                m_sig = fold(m_sig, dq[got]);
                got++;
                m_cnt = 16'(got);
                if (got == n) begin
                    m_busy = 1'b0; m_done = 1'b1; m_pass = (m_sig == gold);
                end
            end
            if (v && got == abort_at) begin
                vif.start = 1'b0;
                vif.resp_valid = 1'b0;
                #2 rst_n = 1'b0;
                #1 model_reset();
                check("abort_busy", {31'd0, vif.busy}, 32'd0);
                check("abort_done", {31'd0, vif.done}, 32'd0);
                check("abort_sig", vif.signature, SEED);
                @(negedge clk); #2 rst_n = 1'b1;
                @(posedge clk); #1;
                return;
            end
        end
        if (guard >= 2000) check("run_timeout", 32'(got), 32'(n));
        vif.start = 1'b0;
        vif.resp_valid = 1'b0;
    endtask

    initial begin
        vif.start = 1'b0; vif.num_samples = '0; vif.settle = '0;
        vif.golden = '0; vif.resp_valid = 1'b0; vif.resp_in = '0;
        vif2.start = 1'b0; vif2.num_samples = '0; vif2.settle = '0;
        vif2.golden = '0; vif2.resp_valid = 1'b0; vif2.resp_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b1;

        // SEED=0 instance: linear compaction, wrong golden
        vif2.start = 1'b1; vif2.num_samples = 16'd2;
        vif2.settle = 4'd0; vif2.golden = 32'h8;
        @(posedge clk); #1 vif2.start = 1'b0;
        @(posedge clk); #1 vif2.resp_valid = 1'b1; vif2.resp_in = 7'h05;
        @(posedge clk); #1;
        check("lin_sig1", vif2.signature, 32'h00000005);
        check("lin_cnt1", {16'd0, vif2.sample_count}, 32'd1);
        vif2.resp_in = 7'h03;
        @(posedge clk); #1;
        vif2.resp_valid = 1'b0;
        check("lin_sig2", vif2.signature, 32'h00000009);
        check("lin_done", {31'd0, vif2.done}, 32'd1);
        check("lin_pass", {31'd0, vif2.pass}, 32'd0);

        // Seed check with zero samples
        dq.delete();
        run(0, 2, 1'b0, 100, '0, 1'b0, -1);
        check("seed_sig", vif.signature, 32'hFFFFFFFF);
        check("seed_model", m_sig, 32'hFFFFFFFF);
        check("seed_done", {31'd0, vif.done}, 32'd1);
        check("seed_pass", {31'd0, vif.pass}, 32'd1);
        check("seed_cnt", {16'd0, vif.sample_count}, 32'd0);
        idle(2);

        // One zero sample with the default polynomial
        dq.delete(); dq.push_back(7'h00);
        run(1, 0, 1'b0, 100, '0, 1'b0, -1);
        check("poly_sig", vif.signature, 32'hFB3EE249);
        check("poly_model", m_sig, 32'hFB3EE249);
        check("poly_pass", {31'd0, vif.pass}, 32'd1);
        idle(3);

        // Valid gaps 1,0,0,1 after a settle of 3
        dq.delete();
        run(2, 3, 1'b0, 0, 32'b1001, 1'b1, -1);
        check("gap_cnt", {16'd0, vif.sample_count}, 32'd2);
        idle(1);

        // Stray starts with other goldens must not alter the verdict
        dq.delete();
        run(8, 1, 1'b0, 70, '0, 1'b0, -1);
        check("busy_start_pass", {31'd0, vif.pass}, 32'd1);
        idle(2);

        // Abort after 3 of 10, then a clean run over the same data
        dq.delete();
        run(10, 2, 1'b0, 80, '0, 1'b0, 3);
        idle(2);
        run(10, 2, 1'b0, 80, '0, 1'b0, -1);
        check("rerun_pass", {31'd0, vif.pass}, 32'd1);
        idle(2);

        // Random runs
        for (int r = 0; r < 25; r++) begin
            dq.delete();
            run($urandom_range(12), $urandom_range(5), 1'($urandom),
                $urandom_range(30, 100), '0, 1'b0, -1);
            idle($urandom_range(3));
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
